// File: rtl/router_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : router_mem_arbiter
// Purpose  : Round-robin arbiter that gives a single-port memory to a read
//            requester and a write requester, one fixed-length burst at a time.
//            A read burst issues BURST_LEN back-to-back read strobes and hands
//            the returned beats to the read side. A write burst forwards
//            BURST_LEN accepted write beats, and stalls on wr_valid gaps.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   read_req       in   read side requests a burst (sampled in IDLE only)
//   read_src_addr  in   read burst base address
//   read_gnt       out  one-cycle pulse, first cycle of a read burst
//   read_done      out  one-cycle pulse carrying the last read beat
//   rd_data        out  read beat data (qualified by rd_valid)
//   rd_valid       out  rd_data valid
//   write_req      in   write side requests a burst (sampled in IDLE only)
//   write_dst_addr in   write burst base address
//   write_gnt      out  one-cycle pulse, first cycle of a write burst
//   write_done     out  one-cycle pulse, first IDLE cycle after a write burst
//   wr_data        in   write beat data
//   wr_valid       in   wr_data valid this cycle
//   mem_en         out  memory access strobe
//   mem_we         out  1 = write, 0 = read
//   mem_addr       out  memory word address (base + beat, wraps)
//   mem_wdata      out  memory write data
//   mem_rdata      in   memory read data, valid the cycle after a read strobe
// ============================================================================
module router_mem_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int BURST_LEN  = 19
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  read_req,
    input  logic [ADDR_WIDTH-1:0] read_src_addr,
    output logic                  read_gnt,
    output logic                  read_done,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,

    input  logic                  write_req,
    input  logic [ADDR_WIDTH-1:0] write_dst_addr,
    output logic                  write_gnt,
    output logic                  write_done,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // Beat counter must hold 0..BURST_LEN-1.
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [BEAT_W-1:0] C_BEAT_ONE  = BEAT_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        RD_DRAIN = 2'd2,
        WR_BURST = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [BEAT_W-1:0]     r_beat;
    logic                  r_last_wr;      // 1 = write side was served last
    logic                  r_read_gnt;
    logic                  r_write_gnt;
    logic                  r_write_done;
    logic                  r_rd_valid;

    // Next-state values
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_base_nxt;
    logic [BEAT_W-1:0]     w_beat_nxt;
    logic                  w_grant_rd;
    logic                  w_grant_wr;
    logic                  w_wr_last;      // final write beat accepted this cycle
    logic [ADDR_WIDTH-1:0] w_beat_addr;

    // Modulo-2^ADDR_WIDTH address: the carry out of the add is simply dropped.
    assign w_beat_addr = r_base + ADDR_WIDTH'(r_beat);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_base_nxt  = r_base;
        w_beat_nxt  = r_beat;
        w_grant_rd  = 1'b0;
        w_grant_wr  = 1'b0;
        w_wr_last   = 1'b0;

        case (r_state)
            IDLE: begin
                // Read wins when alone, or when both ask and write went last.
                if (read_req && (!write_req || r_last_wr)) begin
                    w_grant_rd  = 1'b1;
                    w_state_nxt = RD_BURST;
                    w_base_nxt  = read_src_addr;
                    w_beat_nxt  = '0;
                end else if (write_req) begin
                    w_grant_wr  = 1'b1;
                    w_state_nxt = WR_BURST;
                    w_base_nxt  = write_dst_addr;
                    w_beat_nxt  = '0;
                end
            end

            RD_BURST: begin
                // One read strobe per cycle, no stalls.
                if (r_beat == C_LAST_BEAT) begin
                    w_state_nxt = RD_DRAIN;
                    w_beat_nxt  = '0;
                end else begin
                    w_beat_nxt  = r_beat + C_BEAT_ONE;
                end
            end

            RD_DRAIN: begin
                // Data for the final strobe is on the bus this cycle.
                w_state_nxt = IDLE;
            end

            WR_BURST: begin
                // Only accepted beats advance; wr_valid gaps hold the address.
                if (wr_valid) begin
                    if (r_beat == C_LAST_BEAT) begin
                        w_state_nxt = IDLE;
                        w_beat_nxt  = '0;
                        w_wr_last   = 1'b1;
                    end else begin
                        w_beat_nxt  = r_beat + C_BEAT_ONE;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_beat_nxt  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_base       <= '0;
            r_beat       <= '0;
            r_last_wr    <= 1'b1;   // read side gets the first tie
            r_read_gnt   <= 1'b0;
            r_write_gnt  <= 1'b0;
            r_write_done <= 1'b0;
            r_rd_valid   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_base       <= w_base_nxt;
            r_beat       <= w_beat_nxt;
            r_read_gnt   <= w_grant_rd;
            r_write_gnt  <= w_grant_wr;
            r_write_done <= w_wr_last;
            // Each read strobe yields a valid beat on the following cycle.
            r_rd_valid   <= (r_state == RD_BURST);
            if (w_grant_rd) begin
                r_last_wr <= 1'b0;
            end else if (w_grant_wr) begin
                r_last_wr <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (r_state)
            RD_BURST: begin
                mem_en   = 1'b1;
                mem_addr = w_beat_addr;
            end
            WR_BURST: begin
                mem_en    = wr_valid;
                mem_we    = wr_valid;
                mem_addr  = w_beat_addr;
                mem_wdata = wr_data;
            end
            default: begin
                mem_en    = 1'b0;
            end
        endcase
    end

    assign read_gnt   = r_read_gnt;
    assign write_gnt  = r_write_gnt;
    assign write_done = r_write_done;
    assign read_done  = (r_state == RD_DRAIN);
    assign rd_valid   = r_rd_valid;

    // The memory's own output register already delays read data by one cycle,
    // which lines it up with r_rd_valid; another flop here would skew data a
    // beat behind its valid. Gating keeps rd_data at zero outside valid beats
    // and while reset is held.
    assign rd_data    = r_rd_valid ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_router_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_mem_arbiter
// Purpose  : Self-checking bench for router_mem_arbiter. A table of burst
//            requests drives arbitration, wrap-around and stall cases; short
//            hand-written sequences cover reset and mid-burst requests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 64;
    localparam int BL = 19;

    logic          clk;
    logic          rst_n;
    logic          read_req;
    logic [AW-1:0] read_src_addr;
    logic          read_gnt;
    logic          read_done;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          write_req;
    logic [AW-1:0] write_dst_addr;
    logic          write_gnt;
    logic          write_done;
    logic [DW-1:0] wr_data;
    logic          wr_valid;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    router_mem_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .read_req       (read_req),
        .read_src_addr  (read_src_addr),
        .read_gnt       (read_gnt),
        .read_done      (read_done),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .write_req      (write_req),
        .write_dst_addr (write_dst_addr),
        .write_gnt      (write_gnt),
        .write_done     (write_done),
        .wr_data        (wr_data),
        .wr_valid       (wr_valid),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-only memory image: each word encodes its own address.
    function automatic logic [DW-1:0] rdpat(input logic [AW-1:0] a);
        return {16'hC0DE, 6'd0, a, 22'd0, a};
    endfunction

    function automatic logic [DW-1:0] wpat(input int b);
        return {32'hFACE_B00C, 27'd0, b[4:0]};
    endfunction

    // Synchronous memory: data for a read strobe appears the next cycle.
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= rdpat(mem_addr);
        else                   mem_rdata <= 64'hBAD0_BAD0_BAD0_BAD0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".mem_en"},     64'(mem_en),     64'd0);
        check({tag, ".mem_we"},     64'(mem_we),     64'd0);
        check({tag, ".mem_addr"},   64'(mem_addr),   64'd0);
        check({tag, ".mem_wdata"},  mem_wdata,       64'd0);
        check({tag, ".read_gnt"},   64'(read_gnt),   64'd0);
        check({tag, ".read_done"},  64'(read_done),  64'd0);
        check({tag, ".rd_valid"},   64'(rd_valid),   64'd0);
        check({tag, ".rd_data"},    rd_data,         64'd0);
        check({tag, ".write_gnt"},  64'(write_gnt),  64'd0);
        check({tag, ".write_done"}, 64'(write_done), 64'd0);
    endtask

    typedef struct {
        logic          rreq;
        logic          wreq;
        logic [AW-1:0] raddr;
        logic [AW-1:0] waddr;
        logic          exp_read;   // 1 = read burst expected to win
        logic [AW-1:0] exp_base;
    } vec_t;

    vec_t vecs[6];

    // Request, await the grant, then follow the whole burst beat by beat.
    // raise_w_at >= 0 raises write_req during that read beat.
    task automatic run_burst(input vec_t v, input int raise_w_at);
        int            k;
        int            c;
        int            beats;
        bit            got;
        logic [AW-1:0] a;
        logic [AW-1:0] a_prev;
        read_req       = v.rreq;
        write_req      = v.wreq;
        read_src_addr  = v.raddr;
        write_dst_addr = v.waddr;
        wr_valid       = 1'b1;
        wr_data        = wpat(0);
        got            = 1'b0;
        for (k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            if (read_gnt || write_gnt) begin
                got = 1'b1;
                break;
            end
        end
        check("grant_latency", 64'(k), 64'd0);
        if (!got) begin
            read_req  = 1'b0;
            write_req = 1'b0;
            wr_valid  = 1'b0;
            return;
        end
        check("grant_read_side",  64'(read_gnt),  64'(v.exp_read));
        check("grant_write_side", 64'(write_gnt), 64'(!v.exp_read));
        // Requests dropped right after the grant: the burst must still finish.
        read_req  = 1'b0;
        write_req = 1'b0;

        if (v.exp_read) begin
            wr_valid = 1'b0;
            for (int i = 0; i < BL; i++) begin
                if (i > 0) begin
                    @(negedge clk);
                    if (i == raise_w_at) write_req = 1'b1;
                    #1;
                end
                a      = v.exp_base + AW'(i);
                a_prev = v.exp_base + AW'(i - 1);
                check("rd.mem_en",     64'(mem_en),     64'd1);
                check("rd.mem_we",     64'(mem_we),     64'd0);
                check("rd.mem_addr",   64'(mem_addr),   64'(a));
                check("rd.read_gnt",   64'(read_gnt),   64'(i == 0));
                check("rd.write_gnt",  64'(write_gnt),  64'd0);
                check("rd.read_done",  64'(read_done),  64'd0);
                check("rd.write_done", 64'(write_done), 64'd0);
                check("rd.rd_valid",   64'(rd_valid),   64'(i > 0));
                if (i > 0) check("rd.rd_data", rd_data, rdpat(a_prev));
            end
            @(negedge clk); #1;
            check("drain.read_done", 64'(read_done), 64'd1);
            check("drain.rd_valid",  64'(rd_valid),  64'd1);
            check("drain.rd_data",   rd_data,        rdpat(v.exp_base + AW'(BL - 1)));
            check("drain.mem_en",    64'(mem_en),    64'd0);
            check("drain.mem_addr",  64'(mem_addr),  64'd0);
            @(negedge clk); #1;
            check("idle.read_done",  64'(read_done), 64'd0);
            check("idle.rd_valid",   64'(rd_valid),  64'd0);
            check("idle.mem_en",     64'(mem_en),    64'd0);
        end else begin
            c     = 0;
            beats = 0;
            while (beats < BL && c < 80) begin
                a = v.exp_base + AW'(beats);
                check("wr.mem_en",     64'(mem_en),     64'(wr_valid));
                check("wr.mem_we",     64'(mem_we),     64'(wr_valid));
                check("wr.mem_addr",   64'(mem_addr),   64'(a));
                check("wr.write_gnt",  64'(write_gnt),  64'(c == 0));
                check("wr.read_gnt",   64'(read_gnt),   64'd0);
                check("wr.read_done",  64'(read_done),  64'd0);
                check("wr.write_done", 64'(write_done), 64'd0);
                if (wr_valid) begin
                    check("wr.mem_wdata", mem_wdata, wpat(beats));
                    beats++;
                end
                @(negedge clk);
                c++;
                wr_valid = (c % 3 != 2);
                wr_data  = wpat(beats);
                #1;
            end
            check("wr.beats",       64'(beats),      64'(BL));
            check("wr_end.write_done", 64'(write_done), 64'd1);
            check("wr_end.mem_en",     64'(mem_en),     64'd0);
            check("wr_end.mem_addr",   64'(mem_addr),   64'd0);
            check("wr_end.mem_wdata",  mem_wdata,       64'd0);
            wr_valid = 1'b0;
        end
    endtask

    initial begin
        // Arbitration/burst table with hand-computed winners and bases.
        //          rreq  wreq  raddr    waddr    read? base
        vecs[0] = '{1'b1, 1'b0, 10'h3F0, 10'h000, 1'b1, 10'h3F0}; // read wraps 3FF->000
        vecs[1] = '{1'b0, 1'b1, 10'h000, 10'h010, 1'b0, 10'h010}; // write with gaps
        vecs[2] = '{1'b1, 1'b1, 10'h050, 10'h060, 1'b1, 10'h050}; // tie, write went last
        vecs[3] = '{1'b1, 1'b1, 10'h070, 10'h080, 1'b0, 10'h080}; // tie, read went last
        vecs[4] = '{1'b1, 1'b1, 10'h090, 10'h0A0, 1'b1, 10'h090}; // tie, alternates back
        vecs[5] = '{1'b0, 1'b1, 10'h000, 10'h3FA, 1'b0, 10'h3FA}; // write wraps

        rst_n          = 1'b0;
        read_req       = 1'b0;
        write_req      = 1'b0;
        read_src_addr  = '0;
        write_dst_addr = '0;
        wr_data        = '0;
        wr_valid       = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("post_reset.mem_en", 64'(mem_en), 64'd0);
        end

        for (int i = 0; i < 6; i++) run_burst(vecs[i], -1);
        @(negedge clk); #1;
        check("write_done_single", 64'(write_done), 64'd0);

        // Write request arriving mid read burst waits for the read to finish.
        run_burst('{1'b1, 1'b0, 10'h200, 10'h300, 1'b1, 10'h200}, 3);
        run_burst('{1'b0, 1'b1, 10'h000, 10'h300, 1'b0, 10'h300}, -1);
        @(negedge clk); #1;

        // Reset pulse at beat 7 of a read burst.
        read_req      = 1'b1;
        read_src_addr = 10'h100;
        begin : wait_gnt
            bit got;
            got = 1'b0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk); #1;
                if (read_gnt) begin
                    got = 1'b1;
                    break;
                end
            end
            check("abort.grant_seen", 64'(got), 64'd1);
        end
        read_req = 1'b0;
        repeat (7) @(negedge clk);
        #1;
        check("abort.beat7_addr", 64'(mem_addr), 64'h107);
        rst_n = 1'b0;
        #1;
        check_all_zero("abort.async");
        @(negedge clk); #1;
        check_all_zero("abort.held");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("abort.no_read_done", 64'(read_done), 64'd0);
            check("abort.mem_en",       64'(mem_en),    64'd0);
        end
        // Last-served is back to WRITE: a tie goes to read, from beat 0.
        run_burst('{1'b1, 1'b1, 10'h100, 10'h140, 1'b1, 10'h100}, -1);
        run_burst('{1'b1, 1'b1, 10'h180, 10'h1C0, 1'b0, 10'h1C0}, -1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/router_mem_arbiter.md
ROUTER_MEM_ARBITER -- requirements
Module: router_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, memory word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, memory/link data width.
REQ-003 SHALL have parameter BURST_LEN, default 19, beats per granted burst (packets per frame).
REQ-004 SHALL have port clk  input  1  clock, all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port read_req  input  1  read requester wants a burst.
REQ-007 SHALL have port read_src_addr  input  ADDR_WIDTH  read burst base address.
REQ-008 SHALL have port read_gnt  output  1  read burst granted pulse.
REQ-009 SHALL have port read_done  output  1  read burst complete pulse.
REQ-010 SHALL have port rd_data  output  DATA_WIDTH  read beat data.
REQ-011 SHALL have port rd_valid  output  1  rd_data valid.
REQ-012 SHALL have port write_req  input  1  write requester wants a burst.
REQ-013 SHALL have port write_dst_addr  input  ADDR_WIDTH  write burst base address.
REQ-014 SHALL have port write_gnt  output  1  write burst granted pulse.
REQ-015 SHALL have port write_done  output  1  write burst complete pulse.
REQ-016 SHALL have port wr_data  input  DATA_WIDTH  write beat data.
REQ-017 SHALL have port wr_valid  input  1  wr_data valid this cycle.
REQ-018 SHALL have port mem_en  output  1  memory access strobe.
REQ-019 SHALL have port mem_we  output  1  1 = write, 0 = read.
REQ-020 SHALL have port mem_addr  output  ADDR_WIDTH  memory address.
REQ-021 SHALL have port mem_wdata  output  DATA_WIDTH  memory write data.
REQ-022 SHALL have port mem_rdata  input  DATA_WIDTH  memory read data, valid one cycle after a read strobe.

Function
REQ-023 SHALL implement states IDLE, RD_BURST, RD_DRAIN, WR_BURST.
REQ-024 SHALL sample read_req/write_req only in IDLE; requests are ignored in all other states.
REQ-025 SHALL, in IDLE with exactly one request high, enter the matching burst state next cycle.
REQ-026 SHALL, in IDLE with both requests high, grant the side not served last (round-robin); last-served resets to WRITE so read wins first.
REQ-027 SHALL latch the base address and clear beat counter on the IDLE->burst transition.
REQ-028 SHALL assert read_gnt/write_gnt for exactly the first cycle of RD_BURST/WR_BURST.
REQ-029 SHALL, in RD_BURST, drive mem_en=1, mem_we=0, mem_addr=base+beat every cycle, beat 0..BURST_LEN-1, then enter RD_DRAIN.
REQ-030 SHALL register rd_data<=mem_rdata and rd_valid=1 the cycle after each read strobe, giving BURST_LEN consecutive valid beats.
REQ-031 SHALL spend one cycle in RD_DRAIN carrying the last rd_valid, assert read_done that cycle, then return to IDLE.
REQ-032 SHALL, in WR_BURST, drive mem_en=mem_we=wr_valid, mem_wdata=wr_data, mem_addr=base+beat; beat advances only when wr_valid=1 (gaps stall).
REQ-033 SHALL, on the cycle the BURST_LEN-th write beat is accepted, return to IDLE and pulse write_done in the first IDLE cycle.
REQ-034 SHALL compute base+beat modulo 2^ADDR_WIDTH (wrap to 0, no carry out).
REQ-035 SHALL drive mem_en=mem_we=0 and mem_addr=0 in IDLE and RD_DRAIN.
REQ-036 SHALL accept a new arbitration in the first IDLE cycle after a burst (no dead cycle beyond IDLE).
REQ-037 SHALL complete a granted burst even if its requester drops req mid-burst.

Reset
REQ-038 SHALL, while rst_n=0, force state IDLE, beat counter 0, last-served WRITE, and all outputs 0, including mid-burst (burst abandoned, no done pulse).

Verification
REQ-039 Reset: rst_n=0 -> all outputs 0; release with no requests -> mem_en stays 0.
REQ-040 Single read, read_src_addr=0x3F0 -> read_gnt one cycle, mem_addr 0x3F0..0x3FF,0x000..0x002 (19 beats, wrap), 19 rd_valid beats, read_done with last beat.
REQ-041 read_req and write_req high together after reset -> read burst first, write_gnt in cycle after read_done IDLE cycle; repeat both high -> write then read alternate.
REQ-042 Write burst, write_dst_addr=0x010, wr_valid low every third cycle -> exactly 19 writes to 0x010..0x022, no address advance on gaps, write_done one cycle after last beat.
REQ-043 rst_n pulsed low at beat 7 of read burst -> outputs 0 immediately, no read_done, next read_req restarts from beat 0.
REQ-044 write_req raised during RD_BURST -> no grant until read burst completes, then write_gnt.
